// File: rtl/ram_master_pkg.sv
// Shared state encoding and default geometry for the SOM image/weight RAM burst master.
package ram_master_pkg;

  localparam int RAM_AW        = 18;
  localparam int RAM_DW        = 24;
  localparam int RAM_LW        = 16;
  localparam int RAM_MEM_DEPTH = 61440;  // 4096 * 15 words

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    FIN
  } state_t;

endpackage

// File: rtl/ram_addr_gen.sv
// Burst address/remaining counter: loads on command accept, steps with wrap modulo MEM_DEPTH.
// Registered outputs; the caller only steps while beats remain.
module ram_addr_gen
  import ram_master_pkg::*;
#(
  parameter int AW        = RAM_AW,
  parameter int LW        = RAM_LW,
  parameter int MEM_DEPTH = RAM_MEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [LW-1:0] load_len,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic [LW-1:0] remaining,
  output logic          last
);

  localparam logic [AW:0] DEPTH = (AW+1)'(MEM_DEPTH);

  logic [AW:0] addr_inc;

  assign addr_inc = {1'b0, addr} + (AW+1)'(1);
  assign last     = (remaining == LW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= (addr_inc >= DEPTH) ? AW'(addr_inc - DEPTH) : AW'(addr_inc);
      remaining <= remaining - LW'(1);
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the SOM 24-bit RAM: one word/cycle, 1-cycle read latency, read stalls on rready with A held.
// RAM_BURST_BOUND_CHECK_EN: out-of-range commands are handshaken, flagged on err and dropped; otherwise err = 0.
module ram_burst_master
  import ram_master_pkg::*;
#(
  parameter int AW        = RAM_AW,
  parameter int DW        = RAM_DW,
  parameter int LW        = RAM_LW,
  parameter int MEM_DEPTH = RAM_MEM_DEPTH
) (
  input  logic          CK,
  input  logic          RST_N,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] wdata,
  input  logic          wvalid,
  output logic          wready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  input  logic          rready,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] A,
  output logic          WE,
  output logic          OE,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q
);

  state_t        state;
  logic          pending;
  logic [AW-1:0] addr;
  logic [LW-1:0] remaining;
  logic          last;
  logic          cmd_take;
  logic          bad_cmd;
  logic          load;
  logic          step;
  logic          rem_zero;
  logic          rd_go;

  assign cmd_ready = (state == IDLE);
  assign wready    = (state == WR);
  assign cmd_take  = cmd_valid && cmd_ready;
  assign rem_zero  = (remaining == '0);
  // Capture and the next issue share one edge; both freeze while a read beat is stalled.
  assign rd_go     = !rvalid || rready;

`ifdef RAM_BURST_BOUND_CHECK_EN
  localparam int EW = ((AW > LW) ? AW : LW) + 1;
  logic [EW-1:0] cmd_end;
  assign cmd_end = EW'(cmd_addr) + EW'(cmd_len);
  assign bad_cmd = (EW'(cmd_addr) >= EW'(MEM_DEPTH)) || (cmd_end > EW'(MEM_DEPTH));
`else
  assign bad_cmd = 1'b0;
  assign err     = 1'b0;
`endif

  assign load = cmd_take && !bad_cmd;
  assign step = ((state == WR) && wvalid) || ((state == RD) && rd_go && !rem_zero);

  ram_addr_gen #(
    .AW       (AW),
    .LW       (LW),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_addr_gen (
    .clk      (CK),
    .rst_n    (RST_N),
    .load     (load),
    .load_addr(cmd_addr),
    .load_len (cmd_len),
    .step     (step),
    .addr     (addr),
    .remaining(remaining),
    .last     (last)
  );

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state   <= IDLE;
      A       <= '0;
      WE      <= 1'b0;
      OE      <= 1'b0;
      D       <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      pending <= 1'b0;
      done    <= 1'b0;
`ifdef RAM_BURST_BOUND_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef RAM_BURST_BOUND_CHECK_EN
      err  <= 1'b0;
`endif
      if ((state != RD) && rready) rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (cmd_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= cmd_write ? WR : RD;
            end
          end
`ifdef RAM_BURST_BOUND_CHECK_EN
          if (cmd_take && bad_cmd) err <= 1'b1;
`endif
        end
        WR: begin
          WE <= wvalid;
          if (wvalid) begin
            A <= addr;
            D <= wdata;
            if (last) begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RD: begin
          if (rd_go) begin
            rvalid <= pending;
            if (pending) rdata <= Q;
            if (!rem_zero) begin
              A       <= addr;
              OE      <= 1'b1;
              pending <= 1'b1;
            end else begin
              pending <= 1'b0;
              OE      <= 1'b0;
              state   <= FIN;
              done    <= 1'b1;
            end
          end
        end
        FIN: begin
          WE    <= 1'b0;
          OE    <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: a RAM model on the pins, scoreboards for write pin beats and read stream beats.
// Define RAM_BURST_BOUND_CHECK_EN for both bench and RTL to exercise command rejection instead of wrap.
module tb_ram_burst_master;

  localparam int AW    = 18;
  localparam int DW    = 24;
  localparam int LW    = 16;
  localparam int DEPTH = 61440;

  logic          CK = 1'b0;
  logic          RST_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wdata = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          done;
  logic          err;
  logic [AW-1:0] A;
  logic          WE;
  logic          OE;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  int vectors = 0;
  int miscompares = 0;
  int we_cycles = 0;
  int rd_count = 0;

  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] wr_e;
  logic [DW-1:0]    rd_e;
  logic [DW-1:0]    ram[DEPTH];
  logic [DW-1:0]    ref_mem[DEPTH];
  logic [AW-1:0]    ram_a = '0;

  always #5 CK = ~CK;

  ram_burst_master dut (
    .CK(CK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .done(done), .err(err),
    .A(A), .WE(WE), .OE(OE), .D(D), .Q(Q)
  );

  // RAM model: address latched on the falling edge, Q combinational, write on the rising edge.
  always @(negedge CK) ram_a <= A;
  assign Q = (int'(ram_a) < DEPTH) ? ram[ram_a] : '0;
  always @(posedge CK) if (WE && int'(A) < DEPTH) ram[A] <= D;

  always @(negedge CK) begin
    if (WE) begin
      we_cycles++;
      vectors++;
      if (exp_wr.size() == 0) begin
        miscompares++;
        $display("FAIL wr_pins: got A=%h D=%h, expected no write", A, D);
      end else begin
        wr_e = exp_wr.pop_front();
        if ({A, D} !== wr_e) begin
          miscompares++;
          $display("FAIL wr_pins: got A=%h D=%h, expected A=%h D=%h", A, D, wr_e[AW+DW-1:DW], wr_e[DW-1:0]);
        end
      end
    end
  end

  always @(negedge CK) begin
    if (RST_N && rvalid && rready) begin
      rd_count++;
      vectors++;
      if (exp_rd.size() == 0) begin
        miscompares++;
        $display("FAIL rd_beat: got %h, expected no beat", rdata);
      end else begin
        rd_e = exp_rd.pop_front();
        if (rdata !== rd_e) begin
          miscompares++;
          $display("FAIL rd_beat: got %h, expected %h", rdata, rd_e);
        end
      end
    end
  end

  function automatic logic [AW-1:0] next_a(input logic [AW-1:0] a);
    return (int'(a) == DEPTH - 1) ? '0 : a + AW'(1);
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] base_d,
                          input bit gaps);
    logic [AW-1:0] a;
    int idx, we0, cyc;
    bit seen;
    a = addr; idx = 0; we0 = we_cycles; seen = 0; cyc = 0;
    @(posedge CK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = LW'(len);
    wvalid = 1'b0; wdata = base_d;
    @(negedge CK);
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL wr_cmd_ready: got %b, expected 1", cmd_ready); end
    @(posedge CK); #1;
    cmd_valid = 1'b0;
    wvalid = (len > 0);
    while (cyc < 100 && !seen) begin
      @(negedge CK);
      cyc++;
      if (done) seen = 1;
      else begin
        if (wready && wvalid) begin
          exp_wr.push_back({a, wdata});
          ref_mem[a] = wdata;
          a = next_a(a);
          idx++;
        end
        @(posedge CK); #1;
        wdata = base_d + DW'(idx);
        wvalid = (idx < len) && (!gaps || (cyc % 3 != 1));
      end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL wr_done: got no done in %0d cycles, expected done", cyc); end
    if (!gaps) begin
      vectors++;
      if (cyc != len + 1) begin miscompares++; $display("FAIL wr_done_latency: got %0d, expected %0d", cyc, len + 1); end
    end
    @(negedge CK);
    vectors++;
    if (we_cycles - we0 != len) begin miscompares++; $display("FAIL wr_we_count: got %0d, expected %0d", we_cycles - we0, len); end
    vectors++;
    if ({done, WE, OE, cmd_ready, wready} !== 5'b00010) begin
      miscompares++;
      $display("FAIL wr_after_done: got done/WE/OE/cmd_ready/wready=%b, expected 00010", {done, WE, OE, cmd_ready, wready});
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len, input int stall_n);
    logic [AW-1:0] a, held_a;
    logic [DW-1:0] held_d;
    int got0, stall_left, cyc;
    bit seen, stalled, first;
    a = addr;
    for (int i = 0; i < len; i++) begin exp_rd.push_back(ref_mem[a]); a = next_a(a); end
    got0 = rd_count; seen = 0; stalled = 0; stall_left = 0; cyc = 0;
    held_a = '0; held_d = '0;
    @(posedge CK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = LW'(len); rready = 1'b1;
    @(negedge CK);
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rd_cmd_ready: got %b, expected 1", cmd_ready); end
    @(posedge CK); #1;
    cmd_valid = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge CK);
      cyc++;
      if (!rready) begin
        if (stall_left == stall_n) begin
          held_a = A; held_d = rdata;
          vectors++;
          if (held_a !== next_a(next_a(addr))) begin
            miscompares++;
            $display("FAIL rd_stall_addr: got A=%h, expected %h", held_a, next_a(next_a(addr)));
          end
        end else begin
          vectors++;
          if ({A, rdata} !== {held_a, held_d}) begin
            miscompares++;
            $display("FAIL rd_stall_hold: got A=%h rdata=%h, expected A=%h rdata=%h", A, rdata, held_a, held_d);
          end
        end
        vectors++;
        if (rvalid !== 1'b1) begin miscompares++; $display("FAIL rd_stall_valid: got %b, expected 1", rvalid); end
        stall_left--;
      end
      if (done) begin
        seen = 1;
        vectors++;
        if (rvalid !== 1'b1) begin miscompares++; $display("FAIL rd_last_with_done: got rvalid=%b, expected 1", rvalid); end
      end else begin
        first = !stalled && rvalid && rready && (stall_n > 0);
        @(posedge CK); #1;
        if (first) begin stalled = 1; stall_left = stall_n; rready = 1'b0; end
        else if (!rready && stall_left == 0) rready = 1'b1;
      end
    end
    rready = 1'b1;
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rd_done: got no done in %0d cycles, expected done", cyc); end
    vectors++;
    if (cyc != len + 2 + stall_n) begin miscompares++; $display("FAIL rd_done_latency: got %0d, expected %0d", cyc, len + 2 + stall_n); end
    @(negedge CK);
    vectors++;
    if (rd_count - got0 != len || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL rd_beats: got %0d delivered (%0d left), expected %0d", rd_count - got0, exp_rd.size(), len);
    end
    vectors++;
    if ({done, rvalid, OE, cmd_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL rd_after_done: got done/rvalid/OE/cmd_ready=%b, expected 0001", {done, rvalid, OE, cmd_ready});
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    vectors++;
    if ({cmd_ready, wready, WE, OE, rvalid, done, err} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, expected 1000000", {cmd_ready, wready, WE, OE, rvalid, done, err});
    end
    vectors++;
    if (A !== '0) begin miscompares++; $display("FAIL reset_A: got %h, expected 0", A); end
    vectors++;
    if (D !== '0) begin miscompares++; $display("FAIL reset_D: got %h, expected 0", D); end
    vectors++;
    if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %h, expected 0", rdata); end
    RST_N = 1'b1;
  endtask

  task automatic test_write_burst();
    do_write(18'h00010, 4, 24'hA00001, 1'b0);
    do_read(18'h00010, 4, 0);
  endtask

  task automatic test_read_backpressure();
    do_write(18'h00100, 6, 24'hB00100, 1'b0);
    do_read(18'h00100, 6, 3);
  endtask

  task automatic test_zero_length();
    @(posedge CK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h00055; cmd_len = '0;
    @(posedge CK); #1;
    cmd_valid = 1'b0;
    vectors++;
    if ({done, WE, OE, cmd_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL zero_len_done: got done/WE/OE/cmd_ready=%b, expected 1000", {done, WE, OE, cmd_ready});
    end
    @(posedge CK); #1;
    vectors++;
    if ({done, WE, OE, cmd_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL zero_len_after: got done/WE/OE/cmd_ready=%b, expected 0001", {done, WE, OE, cmd_ready});
    end
  endtask

`ifdef RAM_BURST_BOUND_CHECK_EN
  task automatic test_bound_check();
    @(posedge CK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'(61438); cmd_len = 16'd4; wvalid = 1'b1;
    @(posedge CK); #1;
    cmd_valid = 1'b0; wvalid = 1'b0;
    vectors++;
    if ({err, WE, OE, done, wready, cmd_ready} !== 6'b100001) begin
      miscompares++;
      $display("FAIL bound_err: got err/WE/OE/done/wready/cmd_ready=%b, expected 100001", {err, WE, OE, done, wready, cmd_ready});
    end
    @(posedge CK); #1;
    vectors++;
    if ({err, WE, OE, done, cmd_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL bound_after: got err/WE/OE/done/cmd_ready=%b, expected 00001", {err, WE, OE, done, cmd_ready});
    end
  endtask
`else
  task automatic test_wrap();
    do_write(18'(DEPTH - 1), 3, 24'hC00001, 1'b0);
    do_read(18'(DEPTH - 1), 3, 0);
  endtask
`endif

  task automatic test_back_to_back();
    do_write(18'h00200, 5, 24'hD00200, 1'b1);
    do_read(18'h00200, 5, 0);
    do_write(18'h00300, 2, 24'hE00300, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    logic [AW-1:0] a;
    int cyc;
    bit seen_v, bad;
    a = 18'h00100;
    for (int i = 0; i < 8; i++) begin exp_rd.push_back(ref_mem[a]); a = next_a(a); end
    @(posedge CK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h00100; cmd_len = 16'd8; rready = 1'b1;
    @(posedge CK); #1;
    cmd_valid = 1'b0;
    seen_v = 0; cyc = 0;
    while (!seen_v && cyc < 20) begin
      @(negedge CK);
      cyc++;
      if (rvalid) seen_v = 1;
    end
    vectors++;
    if (!seen_v) begin miscompares++; $display("FAIL rst_mid_start: got no read beat, expected one"); end
    @(posedge CK); #1;
    RST_N = 1'b0;
    @(posedge CK); #1;
    vectors++;
    if ({OE, WE, rvalid, done, cmd_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL rst_mid_pins: got OE/WE/rvalid/done/cmd_ready=%b, expected 00001", {OE, WE, rvalid, done, cmd_ready});
    end
    exp_rd.delete();
    RST_N = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge CK);
      if (done || rvalid || OE) bad = 1;
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL rst_mid_quiet: got activity after reset, expected none"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_burst();
    test_read_backpressure();
`ifdef RAM_BURST_BOUND_CHECK_EN
    test_bound_check();
`else
    test_wrap();
`endif
    test_zero_length();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Burst initiator for the single-port 24-bit image/weight RAM used by the SOM processing system. It accepts read or write burst commands from the SOM engine and drives the RAM pins (A, WE, OE, D). It returns read words from Q on a valid/ready stream and sustains one word per cycle when downstream does not stall. It is the requester-side counterpart of the RAM responder.

## Interface
Parameters:
- AW, 18, RAM address width
- DW, 24, RAM data width
- LW, 16, burst length field width
- MEM_DEPTH, 61440, number of RAM words (4096*15)

Ports:
- CK  input  1  clock; all logic on rising edge
- RST_N  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  AW  first word address
- cmd_len  input  LW  number of words; 0 is legal
- wdata  input  DW  write beat data
- wvalid  input  1  write beat offered
- wready  output  1  high only in WR
- rdata  output  DW  read beat data (registered)
- rvalid  output  1  read beat valid
- rready  input  1  downstream accepts read beat
- done  output  1  one-cycle pulse after the last beat completes
- err  output  1  one-cycle pulse when a command is rejected (macro only)
- A  output  AW  RAM address (registered)
- WE  output  1  RAM write enable (registered)
- OE  output  1  RAM output enable (registered)
- D  output  DW  RAM write data (registered)
- Q  input  DW  RAM read data, combinational from the RAM's negedge-latched address

## Operation
- States: IDLE, WR, RD, FIN.
- Command handshake: a command is taken on cmd_valid && cmd_ready. The block latches addr and len and sets remaining = len.
  - len == 0: go to FIN; no pin activity.
  - Otherwise: go to WR or RD according to cmd_write.
- WR:
  - wready = 1.
  - Each beat with wvalid && wready registers A <= addr, D <= wdata, WE <= 1. addr advances and remaining decrements.
  - A cycle with no beat registers WE <= 0.
  - When the last beat is taken, go to FIN.
- RD: one beat is in flight at a time, with issue and capture overlapped.
  - Issue: registers A <= addr, OE <= 1, sets pending, advances addr, decrements remaining.
  - Capture: a pending beat is captured into rdata/rvalid at an edge where !rvalid || rready. The next issue happens at that same edge.
  - rvalid stall: if rvalid && !rready, A is held unchanged, so Q stays stable. Neither capture nor issue occurs.
  - rvalid clears when rready is high and no capture occurs at that edge.
  - When remaining == 0 and the last beat is captured, OE <= 0 and go to FIN.
- FIN: WE <= 0, OE <= 0, done = 1 for one cycle, then IDLE.
- Address wrap: the address increments modulo MEM_DEPTH, so MEM_DEPTH-1 is followed by 0. Arithmetic is unsigned; remaining is LW bits.
- Reset values: state IDLE; A = 0, WE = 0, OE = 0, D = 0, rdata = 0, rvalid = 0, done = 0, err = 0. After reset cmd_ready = 1, wready = 0.
- Reset mid-burst: the burst is abandoned at that edge. WE and OE are low after the edge, no done pulse, and the in-flight read beat is discarded.

## Timing
- Write: a beat taken at edge e gives WE/A/D valid during cycle e..e+1. The RAM writes at edge e+1.
- Read: issue at edge e, the RAM latches A at the following negedge, and rdata is captured at edge e+1. Latency is 1 cycle; throughput is 1 word/cycle with rready held high.
- done: asserted in the cycle after the final write beat, or in the cycle after the final read capture.
- cmd_ready is combinational from state. A new command cannot be accepted in the same cycle as done.
- cmd_len == 0: done is high in the cycle after acceptance.

## Configuration
- RAM_BURST_BOUND_CHECK_EN
  - Defined: a command with cmd_addr >= MEM_DEPTH or cmd_addr + cmd_len > MEM_DEPTH is still handshaken. The block pulses err for one cycle, performs no pin activity, gives no done, and stays in IDLE.
  - Undefined: err is tied 0, and addresses wrap modulo MEM_DEPTH as described above.

## Structure
- Package ram_master_pkg holds:
  - state enum (IDLE/WR/RD/FIN)
  - AW, DW, LW, MEM_DEPTH defaults
- Sub-module ram_addr_gen holds the address counter:
  - load, increment-with-wrap, remaining counter, last flag
  - instantiated once

## Test plan
- Write burst: addr 0x00010, len 4, data 0xA00001..0xA00004 with wvalid always high → WE high for 4 consecutive cycles with A = 0x10..0x13, done one cycle later; a following read returns the same four words.
- Read under backpressure: preload 0x0100..0x0105, read len 6 with rready low for 3 cycles after the first rvalid → A held stable during the stall, all 6 words delivered in order with none lost or duplicated.
- Wrap: write len 3 at addr 61439 (undefined macro) → A sequence 61439, 0, 1.
- Bound check (macro defined): addr 61438, len 4 → err pulse, no WE/OE activity, cmd_ready high next cycle.
- Zero length: cmd_len 0 → done in the next cycle, WE = OE = 0 throughout.
- Reset mid-read: RST_N low in the 2nd beat of a len 8 read → next cycle OE = 0, rvalid = 0, no done, cmd_ready = 1.
